// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register sentinel, control FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] S_INS = 2'b00;
    localparam logic [1:0] S_AOK = 2'b01;
    localparam logic [1:0] S_HLT = 2'b10;
    localparam logic [1:0] S_ADR = 2'b11;

    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard control with run/drain/halt sequencing and perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [3:0] NONE_REG = R_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    state_t state_q, state_d;

    logic lu, rt, mp, xm, xw;
    logic frozen;

    assign lu = ((E_icode == I_MRMOV) || (E_icode == I_POP))
              && (E_dstM != NONE_REG)
              && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == I_RET) || (E_icode == I_RET)
              || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_Cnd;
    assign xm = (m_stat != S_AOK);
    assign xw = (W_stat != S_AOK);

    assign frozen = (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            final_stat <= S_AOK;
        end else begin
            state_q <= state_d;
            if (!frozen && xw) begin
                final_stat <= W_stat;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        F_stall  = lu || rt;
        D_stall  = lu;
        D_bubble = mp || (rt && !lu);
        E_bubble = mp || lu;
        M_bubble = xm || xw;
        W_stall  = xw;
        set_cc   = (E_icode == I_OPQ) && !xm && !xw;
        halted   = 1'b0;
        case (state_q)
            RUN: begin
                if (xw) begin
                    state_d = HALTED;
                end else if (xm) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xw) begin
                    state_d = HALTED;
                end else if (!xm) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d  = HALTED;
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
                set_cc   = 1'b0;
                halted   = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    logic inc_cyc, inc_ret, inc_stall, inc_bub;

    assign inc_cyc   = !frozen;
    // W_stall is already folded in: it is 1 whenever HALTED or W_stat is non-AOK
    assign inc_ret   = !frozen && (W_stat == S_AOK)
                     && (W_icode != I_NOP) && !W_stall;
    assign inc_stall = !frozen && lu;
    assign inc_bub   = !frozen && D_bubble && !lu;

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk (clk),
        .rst (rst),
        .inc (inc_cyc),
        .q   (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret (
        .clk (clk),
        .rst (rst),
        .inc (inc_ret),
        .q   (ret_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .inc (inc_stall),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bub (
        .clk (clk),
        .rst (rst),
        .inc (inc_bub),
        .q   (bub_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (32-bit and 4-bit counter instances).
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_Cnd;
    logic [1:0] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic        set_cc, halted;
    logic [1:0]  final_stat;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;

    logic       F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4;
    logic       set_cc4, halted4;
    logic [1:0] final_stat4;
    logic [3:0] cyc_cnt4, ret_cnt4, stall_cnt4, bub_cnt4;

    int tests = 0;
    int fails = 0;
    int exp_cyc = 0;
    bit exp_halted = 0;
    logic [31:0] held_cyc;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4),
        .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
        .set_cc(set_cc4), .halted(halted4), .final_stat(final_stat4),
        .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4),
        .stall_cnt(stall_cnt4), .bub_cnt(bub_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
        M_icode = 4'h1; m_stat = 2'b01;
        W_icode = 4'h1; W_stat = 2'b01;
    endtask

    // one clock edge; bench cycle model advances only while not halted
    task automatic tick();
        @(posedge clk);
        if (!exp_halted) exp_cyc++;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cyc = 0;
        exp_halted = 0;
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {F_stall, D_stall, D_bubble, E_bubble,
                  M_bubble, W_stall, set_cc}, {25'd0, exp});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        do_reset();
        chk("rst_halted", halted, 0);
        chk("rst_final", final_stat, 2'b01);
        chk("rst_cnts", cyc_cnt | ret_cnt | stall_cnt | bub_cnt, 0);
        // F D Db Eb Mb W cc
        chk_ctl("rst_ctl", 7'b0000000);

        // load-use
        D_icode = 4'h6; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        chk_ctl("lu_ctl", 7'b1101000);
        chk("lu_cnt0", stall_cnt, 0);
        tick();
        chk("lu_cnt1", stall_cnt, 1);
        chk("cyc_a", cyc_cnt, exp_cyc);

        // srcB match also triggers, NONE_REG never does
        d_srcA = 4'h2; d_srcB = 4'h3;
        #1;
        chk("lu_srcB", D_stall, 1);
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        #1;
        chk("lu_none", {F_stall, D_stall}, 0);

        // mispredict
        idle();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk_ctl("mp_ctl", 7'b0011000);
        tick();
        chk("mp_bub", bub_cnt, 1);
        e_Cnd = 1'b1;
        #1;
        chk_ctl("taken_ctl", 7'b0000000);
        tick();
        chk("taken_bub", bub_cnt, 1);

        // ret walks D -> E -> M
        idle();
        D_icode = 4'h9;
        #1;
        chk_ctl("ret_D", 7'b1010000);
        tick();
        D_icode = 4'h1; E_icode = 4'h9;
        #1;
        chk_ctl("ret_E", 7'b1010000);
        tick();
        E_icode = 4'h1; M_icode = 4'h9;
        #1;
        chk_ctl("ret_M", 7'b1010000);
        tick();
        chk("ret_bub", bub_cnt, 4);

        // load-use beats ret
        idle();
        E_icode = 4'hB; E_dstM = 4'h4; D_icode = 4'h9; d_srcA = 4'h4;
        #1;
        chk_ctl("lu_ret", 7'b1101000);
        tick();
        chk("lu_ret_stall", stall_cnt, 2);
        chk("lu_ret_bub", bub_cnt, 4);

        // set_cc and retirement
        idle();
        E_icode = 4'h6; W_icode = 4'h6;
        #1;
        chk("setcc", set_cc, 1);
        tick();
        chk("ret1", ret_cnt, 1);
        W_icode = 4'h1;
        tick();
        chk("ret_nop", ret_cnt, 1);

        // exception drain
        idle();
        E_icode = 4'h6; m_stat = 2'b11;
        #1;
        chk_ctl("xm_ctl", 7'b0000100);
        tick();
        chk("drain_halted", halted, 0);
        idle();
        W_icode = 4'h5; W_stat = 2'b11;
        #1;
        chk_ctl("xw_ctl", 7'b0000110);
        tick();
        exp_halted = 1;
        chk("ret_xw", ret_cnt, 1);
        chk("halted", halted, 1);
        chk("final_adr", final_stat, 2'b11);
        chk_ctl("halt_ctl", 7'b1101110);
        chk("cyc_at_halt", cyc_cnt, exp_cyc);
        held_cyc = cyc_cnt;
        idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h6;
        tick();
        tick();
        chk("cyc_frozen", cyc_cnt, held_cyc);
        chk("stall_frozen", stall_cnt, 2);
        chk("ret_frozen", ret_cnt, 1);
        chk("still_halted", {halted, final_stat}, 3'b111);

        // reset while halted
        do_reset();
        chk("rh_halted", halted, 0);
        chk("rh_final", final_stat, 2'b01);
        chk("rh_cnts", cyc_cnt | ret_cnt | stall_cnt | bub_cnt, 0);
        chk_ctl("rh_ctl", 7'b1101000);

        // xm and xw together: W_stat wins
        idle();
        m_stat = 2'b00; W_stat = 2'b10;
        tick();
        exp_halted = 1;
        chk("both_halt", halted, 1);
        chk("both_final", final_stat, 2'b10);

        // saturation on the 4-bit instance
        do_reset();
        idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall4", stall_cnt4, 4'hF);
        chk("sat_cyc4", cyc_cnt4, 4'hF);
        chk("stall32", stall_cnt, 20);
        chk("cyc32", cyc_cnt, exp_cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
